// File: rtl/pdcache.sv
// rtl/pdcache.sv - write-back set-associative data cache with round-robin victims and halt flush
// Defining PDCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module pdcache #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
`ifdef PDCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WOFF_BITS = $clog2(WORDS);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int IDX_LSB   = 2 + WOFF_BITS;
    localparam int TAG_LSB   = IDX_LSB + IDX_BITS;
    localparam int TAG_W     = 32 - TAG_LSB;
    localparam int BEAT_W    = (WORDS > 1) ? WOFF_BITS : 1;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        RESP,
        FLUSH,
        FLUSH_WB,
        FLUSHED
    } state_t;

    state_t                state_q, state_d;
    logic                  valid_q [SETS][WAYS];
    logic                  valid_d [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic                  dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]      tag_d   [SETS][WAYS];
    logic [31:0]           data_q  [SETS][WAYS][WORDS];
    logic [31:0]           data_d  [SETS][WAYS][WORDS];
    logic [WAY_W-1:0]      ptr_q   [SETS];
    logic [WAY_W-1:0]      ptr_d   [SETS];

    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic [IDX_BITS-1:0]   lat_idx_q, lat_idx_d;
    logic [TAG_W-1:0]      lat_tag_q, lat_tag_d;
    logic [BEAT_W-1:0]     lat_word_q, lat_word_d;
    logic                  lat_store_q, lat_store_d;
    logic [31:0]           lat_wdata_q, lat_wdata_d;
    logic [IDX_BITS-1:0]   scan_set_q, scan_set_d;
    logic [WAY_W-1:0]      scan_way_q, scan_way_d;
`ifdef PDCACHE_STATS_EN
    logic [31:0]           hit_count_q, hit_count_d;
    logic [31:0]           miss_count_q, miss_count_d;
`endif

    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [BEAT_W-1:0]     req_word;
    logic                  hit_any;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic                  beat_last;
    logic                  scan_last;
    logic                  scan_way_wrap;
    logic                  hit_c;
    logic [31:0]           load_c;

    function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t,
                                            input logic [IDX_BITS-1:0] i,
                                            input logic [BEAT_W-1:0] b);
        return (32'(t) << TAG_LSB) | (32'(i) << IDX_LSB) | (32'(b) << 2);
    endfunction

    // Lookup; the descending loop leaves the lowest-numbered invalid way as victim.
    always_comb begin
        req_word = BEAT_W'((dmemaddr >> 2) & 32'(WORDS - 1));
        req_idx  = IDX_BITS'(dmemaddr >> IDX_LSB);
        req_tag  = TAG_W'(dmemaddr >> TAG_LSB);
        hit_any  = 1'b0;
        hit_way  = '0;
        victim   = ptr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    assign beat_last     = (beat_q == BEAT_W'(WORDS - 1));
    assign scan_way_wrap = (scan_way_q == WAY_W'(WAYS - 1));
    assign scan_last     = scan_way_wrap && (scan_set_q == IDX_BITS'(SETS - 1));

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        way_d       = way_q;
        lat_idx_d   = lat_idx_q;
        lat_tag_d   = lat_tag_q;
        lat_word_d  = lat_word_q;
        lat_store_d = lat_store_q;
        lat_wdata_d = lat_wdata_q;
        scan_set_d  = scan_set_q;
        scan_way_d  = scan_way_q;
        hit_c       = 1'b0;
        load_c      = '0;
`ifdef PDCACHE_STATS_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (halt) begin
                    scan_set_d = '0;
                    scan_way_d = '0;
                    state_d    = FLUSH;
                end else if (dmemREN || dmemWEN) begin
                    if (hit_any) begin
                        hit_c = 1'b1;
                        if (dmemWEN) begin
                            data_d[req_idx][hit_way][req_word] = dmemstore;
                            dirty_d[req_idx][hit_way]          = 1'b1;
                        end else begin
                            load_c = data_q[req_idx][hit_way][req_word];
                        end
`ifdef PDCACHE_STATS_EN
                        if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
`endif
                    end else begin
                        lat_idx_d   = req_idx;
                        lat_tag_d   = req_tag;
                        lat_word_d  = req_word;
                        lat_store_d = dmemWEN;
                        lat_wdata_d = dmemstore;
                        way_d       = victim;
                        beat_d      = '0;
                        // Invalidate up front so an abandoned burst never leaves a half-filled valid line.
                        valid_d[req_idx][victim] = 1'b0;
                        state_d = dirty_q[req_idx][victim] ? WB : FILL;
`ifdef PDCACHE_STATS_EN
                        if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
`endif
                    end
                end
            end
            WB: begin
                if (!dwait) begin
                    if (beat_last) begin
                        dirty_d[lat_idx_q][way_q] = 1'b0;
                        beat_d  = '0;
                        state_d = FILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (!dwait) begin
                    data_d[lat_idx_q][way_q][beat_q] = dload;
                    if (beat_last) begin
                        valid_d[lat_idx_q][way_q] = 1'b1;
                        dirty_d[lat_idx_q][way_q] = 1'b0;
                        tag_d[lat_idx_q][way_q]   = lat_tag_q;
                        ptr_d[lat_idx_q] = (ptr_q[lat_idx_q] == WAY_W'(WAYS - 1)) ?
                                           '0 : ptr_q[lat_idx_q] + 1'b1;
                        beat_d  = '0;
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RESP: begin
                hit_c = 1'b1;
                if (lat_store_q) begin
                    data_d[lat_idx_q][way_q][lat_word_q] = lat_wdata_q;
                    dirty_d[lat_idx_q][way_q]            = 1'b1;
                end else begin
                    load_c = data_q[lat_idx_q][way_q][lat_word_q];
                end
                state_d = IDLE;
            end
            FLUSH: begin
                valid_d[scan_set_q][scan_way_q] = 1'b0;
                if (dirty_q[scan_set_q][scan_way_q]) begin
                    lat_idx_d = scan_set_q;
                    way_d     = scan_way_q;
                    beat_d    = '0;
                    state_d   = FLUSH_WB;
                end else begin
                    scan_way_d = scan_way_wrap ? '0 : scan_way_q + 1'b1;
                    scan_set_d = scan_way_wrap ? scan_set_q + 1'b1 : scan_set_q;
                    state_d    = scan_last ? FLUSHED : FLUSH;
                end
            end
            FLUSH_WB: begin
                if (!dwait) begin
                    if (beat_last) begin
                        dirty_d[lat_idx_q][way_q] = 1'b0;
                        valid_d[lat_idx_q][way_q] = 1'b0;
                        beat_d     = '0;
                        scan_way_d = scan_way_wrap ? '0 : scan_way_q + 1'b1;
                        scan_set_d = scan_way_wrap ? scan_set_q + 1'b1 : scan_set_q;
                        state_d    = scan_last ? FLUSHED : FLUSH;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FLUSHED: begin
                if (!halt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
            tag_q       <= '{default: '0};
            data_q      <= '{default: '0};
            ptr_q       <= '{default: '0};
            beat_q      <= '0;
            way_q       <= '0;
            lat_idx_q   <= '0;
            lat_tag_q   <= '0;
            lat_word_q  <= '0;
            lat_store_q <= 1'b0;
            lat_wdata_q <= '0;
            scan_set_q  <= '0;
            scan_way_q  <= '0;
`ifdef PDCACHE_STATS_EN
            hit_count_q  <= '0;
            miss_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            way_q       <= way_d;
            lat_idx_q   <= lat_idx_d;
            lat_tag_q   <= lat_tag_d;
            lat_word_q  <= lat_word_d;
            lat_store_q <= lat_store_d;
            lat_wdata_q <= lat_wdata_d;
            scan_set_q  <= scan_set_d;
            scan_way_q  <= scan_way_d;
`ifdef PDCACHE_STATS_EN
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
    end

    // Memory-side outputs decode only registered state, so they hold steady while dwait stalls.
    assign dREN    = (state_q == FILL);
    assign dWEN    = (state_q == WB) || (state_q == FLUSH_WB);
    assign flushed = (state_q == FLUSHED);

    always_comb begin
        daddr  = '0;
        dstore = '0;
        if (dWEN) begin
            daddr  = mk_addr(tag_q[lat_idx_q][way_q], lat_idx_q, beat_q);
            dstore = data_q[lat_idx_q][way_q][beat_q];
        end else if (dREN) begin
            daddr = mk_addr(lat_tag_q, lat_idx_q, beat_q);
        end
    end

    assign dhit     = hit_c & ~RST;
    assign dmemload = RST ? 32'h0 : load_c;

`ifdef PDCACHE_STATS_EN
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_pdcache.sv
// tb/tb_pdcache.sv - directed self-checking bench for pdcache (SETS=8, WAYS=2, WORDS=2)
module tb_pdcache;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
`ifdef PDCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    pdcache #(.SETS(8), .WAYS(2), .WORDS(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .halt      (halt),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload)
`ifdef PDCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Backing memory: unwritten words return a fixed pattern; writes are logged in order.
    logic [31:0] mem      [1024];
    bit          wr_valid [1024];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hAAAA_0000;
        if (a == 32'h104) return 32'hAAAA_0001;
        return 32'hB000_0000 | a;
    endfunction

    assign dload = !dREN ? 32'h0 :
                   (wr_valid[daddr[11:2]] ? mem[daddr[11:2]] : def_word(daddr));

    always begin
        @(negedge CLK);
        #2;
        if (dWEN === 1'b1 && dwait === 1'b0) begin
            mem[daddr[11:2]]      <= dstore;
            wr_valid[daddr[11:2]] <= 1'b1;
            wq_addr.push_back(daddr);
            wq_data.push_back(dstore);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic req(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        dmemREN   = ren;
        dmemWEN   = wen;
        dmemaddr  = a;
        dmemstore = d;
        #1;
    endtask

    task automatic wait_hit(input int maxc, output int lat);
        lat = 0;
        while (dhit !== 1'b1 && lat < maxc) begin
            chkb("rd_wr_exclusive", dREN & dWEN, 1'b0);
            @(negedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic chk_writes(input string tag, input int base, input int n,
                              input logic [31:0] ea [4], input logic [31:0] ed [4]);
        chk({tag, "_count"}, 32'(wq_addr.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, (base + i < wq_addr.size()) ? wq_addr[base + i] : 32'hDEAD_DEAD, ea[i]);
            chk({tag, "_data"}, (base + i < wq_data.size()) ? wq_data[base + i] : 32'hDEAD_DEAD, ed[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        logic [31:0] ea [4];
        logic [31:0] ed [4];

        RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
        halt = 1'b0; dwait = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chkb("rst_dhit", dhit, 1'b0);
        chkb("rst_dREN", dREN, 1'b0);
        chkb("rst_dWEN", dWEN, 1'b0);
        chkb("rst_flushed", flushed, 1'b0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_dstore", dstore, 32'h0);
        chk("rst_dmemload", dmemload, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Cold load miss: two fill beats then RESP at cycle 3.
        req(1'b1, 1'b0, 32'h100, 32'h0);
        chkb("cold_miss_nohit", dhit, 1'b0);
        @(negedge CLK); #1;
        chkb("fill0_dREN", dREN, 1'b1);
        chkb("fill0_dWEN", dWEN, 1'b0);
        chk("fill0_daddr", daddr, 32'h100);
        @(negedge CLK); #1;
        chk("fill1_daddr", daddr, 32'h104);
        chkb("fill1_nohit", dhit, 1'b0);
        @(negedge CLK); #1;
        chkb("resp_dhit", dhit, 1'b1);
        chk("resp_load", dmemload, 32'hAAAA_0000);
        req(1'b1, 1'b0, 32'h104, 32'h0);
        chkb("reload_hit", dhit, 1'b1);
        chk("reload_data", dmemload, 32'hAAAA_0001);

        // Dirty eviction of the 0x100 line by a third tag in set 0.
        req(1'b0, 1'b1, 32'h100, 32'h1234_5678);
        chkb("store_hit", dhit, 1'b1);
        req(1'b1, 1'b0, 32'h100, 32'h0);
        chk("store_readback", dmemload, 32'h1234_5678);
        req(1'b1, 1'b0, 32'h200, 32'h0);
        wait_hit(20, lat);
        chk("miss200_latency", 32'(lat), 32'd3);
        chk("miss200_data", dmemload, 32'hB000_0200);
        base = wq_addr.size();
        req(1'b1, 1'b0, 32'h300, 32'h0);
        wait_hit(20, lat);
        chk("dirty_miss_latency", 32'(lat), 32'd5);
        chk("miss300_data", dmemload, 32'hB000_0300);
        ea[0] = 32'h100; ed[0] = 32'h1234_5678;
        ea[1] = 32'h104; ed[1] = 32'hAAAA_0001;
        chk_writes("evict_wb", base, 2, ea, ed);

        // dwait held high for 5 cycles on the first fill beat.
        dwait = 1'b1;
        req(1'b1, 1'b0, 32'h20, 32'h0);
        chkb("stall_req_nohit", dhit, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1;
            chkb("stall_dREN", dREN, 1'b1);
            chk("stall_daddr", daddr, 32'h20);
            chkb("stall_nohit", dhit, 1'b0);
        end
        @(negedge CLK);
        dwait = 1'b0;
        #1;
        chk("stall_release_daddr", daddr, 32'h20);
        wait_hit(20, lat);
        chk("stall_tail_latency", 32'(lat), 32'd2);
        chk("stall_data", dmemload, 32'hB000_0020);

        // Two dirty lines (set 0 way 0, set 3 way 0), then flush.
        req(1'b0, 1'b1, 32'h300, 32'h1111_1111);
        chkb("store300_hit", dhit, 1'b1);
        req(1'b0, 1'b1, 32'h18, 32'h3333_3333);
        wait_hit(20, lat);
        chk("store18_miss_latency", 32'(lat), 32'd3);
        base = wq_addr.size();
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b1;
        #1;
        chkb("halt_not_flushed_yet", flushed, 1'b0);
        lat = 0;
        while (flushed !== 1'b1 && lat < 100) begin
            @(negedge CLK); #1;
            lat++;
        end
        chk("flush_latency", 32'(lat), 32'd21);
        ea[0] = 32'h300; ed[0] = 32'h1111_1111;
        ea[1] = 32'h304; ed[1] = 32'hB000_0304;
        ea[2] = 32'h18;  ed[2] = 32'h3333_3333;
        ea[3] = 32'h1C;  ed[3] = 32'hB000_001C;
        chk_writes("flush_wb", base, 4, ea, ed);
        @(negedge CLK);
        halt = 1'b0;
        @(negedge CLK); #1;
        chkb("unhalt_flushed_low", flushed, 1'b0);
        req(1'b1, 1'b0, 32'h300, 32'h0);
        chkb("post_flush_miss", dhit, 1'b0);
        wait_hit(20, lat);
        chk("post_flush_latency", 32'(lat), 32'd3);
        chk("post_flush_data", dmemload, 32'h1111_1111);

        // Reset in the middle of the second write-back beat.
        req(1'b1, 1'b0, 32'h200, 32'h0);
        wait_hit(20, lat);
        chk("load200_latency", 32'(lat), 32'd3);
        req(1'b0, 1'b1, 32'h200, 32'h6666_6666);
        chkb("store200_hit", dhit, 1'b1);
        req(1'b1, 1'b0, 32'h100, 32'h0);
        chkb("evict200_nohit", dhit, 1'b0);
        @(negedge CLK); #1;
        chkb("wb0_dWEN", dWEN, 1'b1);
        chk("wb0_daddr", daddr, 32'h200);
        chk("wb0_dstore", dstore, 32'h6666_6666);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("wb1_daddr", daddr, 32'h204);
        @(negedge CLK); #1;
        chkb("rst_mid_dWEN", dWEN, 1'b0);
        chkb("rst_mid_dREN", dREN, 1'b0);
        chk("rst_mid_daddr", daddr, 32'h0);
        chk("rst_mid_dstore", dstore, 32'h0);
        chkb("rst_mid_dhit", dhit, 1'b0);
`ifdef PDCACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chkb("after_rst_miss", dhit, 1'b0);
        wait_hit(20, lat);
        chk("after_rst_latency", 32'(lat), 32'd3);
        chk("after_rst_data", dmemload, 32'h1234_5678);
        req(1'b1, 1'b0, 32'h200, 32'h0);
        chkb("after_rst_200_miss", dhit, 1'b0);
        wait_hit(20, lat);
        chk("after_rst_200_latency", 32'(lat), 32'd3);
        chk("after_rst_200_data", dmemload, 32'h6666_6666);

        @(negedge CLK);
        dmemREN = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
